// File: rtl/riscv_ahb_pkg.sv
// Shared definitions for the PicoRV32 -> AHB single-transfer path.
// Contents: HSIZE encodings, default HPROT values, splitter FSM state type.
// Pure package, no logic.
package riscv_ahb_pkg;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [3:0] PROT_INSTR_DEF = 4'b0000;
    localparam logic [3:0] PROT_DATA_DEF  = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } split_state_e;

endpackage

// File: rtl/picorv32_strb_chunk.sv
// Picks the next AHB-legal transfer out of a remaining byte-lane mask.
// Ports: mask_i (lanes still to do) -> offset_o (byte offset), size_o (HSIZE),
//        consumed_o (lanes this transfer covers). Purely combinational.
module picorv32_strb_chunk
    import riscv_ahb_pkg::*;
#(
    parameter bit COALESCE_HALF = 1'b1
) (
    input  logic [3:0] mask_i,
    output logic [1:0] offset_o,
    output logic [2:0] size_o,
    output logic [3:0] consumed_o
);

    always_comb begin
        offset_o   = 2'd0;
        size_o     = HSIZE_BYTE;
        consumed_o = 4'b0000;
        if (mask_i == 4'b1111) begin
            size_o     = HSIZE_WORD;
            consumed_o = 4'b1111;
        end else if (COALESCE_HALF && mask_i[1:0] == 2'b11) begin
            size_o     = HSIZE_HALF;
            consumed_o = 4'b0011;
        end else if (COALESCE_HALF && mask_i[1:0] == 2'b00 && mask_i[3:2] == 2'b11) begin
            // Upper halfword only once the lower lanes are finished, keeping address order ascending.
            offset_o   = 2'd2;
            size_o     = HSIZE_HALF;
            consumed_o = 4'b1100;
        end else if (mask_i[0]) begin
            consumed_o = 4'b0001;
        end else if (mask_i[1]) begin
            offset_o   = 2'd1;
            consumed_o = 4'b0010;
        end else if (mask_i[2]) begin
            offset_o   = 2'd2;
            consumed_o = 4'b0100;
        end else if (mask_i[3]) begin
            offset_o   = 2'd3;
            consumed_o = 4'b1000;
        end
    end

endmodule

// File: rtl/picorv32_wstrb_splitter.sv
// Splits a PicoRV32 native request into AHB-legal single transfers, one outstanding.
// Ports: clk_i/reset_i; mem_* CPU side (mem_ready_o one-cycle pulse); req_* transfer
//        request (held stable until req_ready_i); resp_* per-transfer completion; err_sticky_o.
module picorv32_wstrb_splitter
    import riscv_ahb_pkg::*;
#(
    parameter bit         COALESCE_HALF = 1'b1,
    parameter logic [3:0] PROT_INSTR    = PROT_INSTR_DEF,
    parameter logic [3:0] PROT_DATA     = PROT_DATA_DEF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mem_valid_i,
    input  logic        mem_instr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic        req_write_o,
    output logic [31:0] req_addr_o,
    output logic [2:0]  req_size_o,
    output logic [31:0] req_wdata_o,
    output logic [3:0]  req_prot_o,
    input  logic        resp_valid_i,
    input  logic [31:0] resp_rdata_i,
    input  logic        resp_err_i,
    output logic        err_sticky_o
);

    split_state_e state_q, state_d;
    logic [31:2]  base_q, base_d;
    logic [31:0]  wdata_q, wdata_d;
    logic         instr_q, instr_d;
    logic         write_q, write_d;
    logic [3:0]   mask_q, mask_d;
    logic [3:0]   consumed_q, consumed_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [2:0]   req_size_q, req_size_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         err_q, err_d;

    logic [1:0]   chunk_off;
    logic [2:0]   chunk_size;
    logic [3:0]   chunk_consumed;

    // Word address only; the byte offset comes from the strobes.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^mem_addr_i[1:0];

    // Evaluated on the next-state mask so the request fields are ready the cycle ISSUE starts.
    picorv32_strb_chunk #(
        .COALESCE_HALF (COALESCE_HALF)
    ) u_chunk (
        .mask_i     (mask_d),
        .offset_o   (chunk_off),
        .size_o     (chunk_size),
        .consumed_o (chunk_consumed)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        instr_d    = instr_q;
        write_d    = write_q;
        mask_d     = mask_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        unique case (state_q)
            ST_IDLE: begin
                // mem_ready is never high in IDLE, so the completing cycle cannot re-trigger.
                if (mem_valid_i) begin
                    base_d  = mem_addr_i[31:2];
                    wdata_d = mem_wdata_i;
                    instr_d = mem_instr_i;
                    write_d = (mem_wstrb_i != 4'b0000);
                    mask_d  = (mem_wstrb_i == 4'b0000) ? 4'b1111 : mem_wstrb_i;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (req_ready_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (resp_valid_i) begin
                    mask_d = mask_q & ~consumed_q;
                    if (!write_q) begin
                        rdata_d = resp_rdata_i;
                    end
                    if (resp_err_i) begin
                        err_d = 1'b1;
                    end
                    // CPU withdrew the request: finish quietly, no completion pulse.
                    if (!mem_valid_i) begin
                        state_d = ST_IDLE;
                    end else if (resp_err_i || mask_d == 4'b0000) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Request fields are loaded on every cycle that ends in ISSUE; mask_d cannot
        // change while in ISSUE, so the outputs stay stable through backpressure.
        req_addr_d = req_addr_q;
        req_size_d = req_size_q;
        consumed_d = consumed_q;
        if (state_d == ST_ISSUE) begin
            req_addr_d = {base_d, chunk_off};
            req_size_d = chunk_size;
            consumed_d = chunk_consumed;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            wdata_q    <= '0;
            instr_q    <= 1'b0;
            write_q    <= 1'b0;
            mask_q     <= '0;
            consumed_q <= '0;
            req_addr_q <= '0;
            req_size_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            instr_q    <= instr_d;
            write_q    <= write_d;
            mask_q     <= mask_d;
            consumed_q <= consumed_d;
            req_addr_q <= req_addr_d;
            req_size_q <= req_size_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign req_valid_o  = (state_q == ST_ISSUE);
    assign mem_ready_o  = (state_q == ST_DONE);
    assign mem_rdata_o  = rdata_q;
    assign req_write_o  = write_q;
    assign req_addr_o   = req_addr_q;
    assign req_size_o   = req_size_q;
    assign req_wdata_o  = wdata_q;
    assign req_prot_o   = instr_q ? PROT_INSTR : PROT_DATA;
    assign err_sticky_o = err_q;

endmodule
